// File: rtl/send_output_number_pkg.sv
// Shared serial-link definitions: word/counter widths and FSM state encodings.
// No logic; used by the transmitter and reusable by the receiver side.
package send_output_number_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bit_counter.sv
// Purpose: 3-bit bit counter with sync clear, count enable and carry-out at the top count.
// Latency: count updates on the enabled edge; co is a decode of the registered count.
// Backpressure: en low freezes the count.
module bit_counter
    import send_output_number_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             co
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign co = &cnt;

endmodule

// File: rtl/send_output_number.sv
// Purpose: MSB-first serial transmitter of an 8-bit word; SEND_OUTPUT_PARITY_EN appends even parity.
// Latency: first bit valid the cycle after start is accepted; done pulses one cycle after the last bit.
// Backpressure: shen low holds the current bit and freezes the bit counter.
module send_output_number
    import send_output_number_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] pin,
    input  logic              shen,
    output logic              serout,
    output logic              serout_valid,
    output logic              busy,
    output logic              done,
    output logic              co
);

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_co;
    logic              in_shift;
`ifdef SEND_OUTPUT_PARITY_EN
    logic              par;
`endif

    assign in_shift = (state == ST_SHIFT);

    bit_counter u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_IDLE && start),
        .en  (in_shift && shen),
        .cnt (cnt),
        .co  (cnt_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
`ifdef SEND_OUTPUT_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg <= pin;
`ifdef SEND_OUTPUT_PARITY_EN
                        par   <= ^pin;
`endif
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shen) begin
                        shreg <= {shreg[WORD_W-2:0], 1'b0};
                        // Counter wraps to 0 on this same edge, ready for the next frame.
                        if (cnt == CNT_MAX) begin
`ifdef SEND_OUTPUT_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef SEND_OUTPUT_PARITY_EN
                ST_PARITY: begin
                    if (shen) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; start/pin never reach them combinationally.
    always_comb begin
        serout       = 1'b0;
        serout_valid = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            ST_SHIFT: begin
                serout       = shreg[WORD_W-1];
                serout_valid = 1'b1;
                busy         = 1'b1;
            end
`ifdef SEND_OUTPUT_PARITY_EN
            ST_PARITY: begin
                serout       = par;
                serout_valid = 1'b1;
                busy         = 1'b1;
            end
`endif
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign co = in_shift && cnt_co;

endmodule
